// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared NoC types for the AXI-stream packet arbiter.
// Holds the arbiter state encoding and the grant index width helper.
package axis_pkt_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Bits needed to index n requesters (never narrower than 1 bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_pkt_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant to the first
// requester found scanning upward from ptr, wrapping around.
module rr_arbiter
    import axis_pkt_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            req,
    input  logic [idx_width(N)-1:0] ptr,
    output logic [N-1:0]            gnt,
    output logic                    valid
);

    // Scan from ptr with wrap; the first active request wins
    always_comb begin
        int k;
        k     = 0;
        gnt   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!valid && req[k]) begin
                gnt[k] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic AXI-stream arbiter: N requesters share one output,
// whole packets are forwarded through a registered output stage.
module axis_pkt_arbiter
    import axis_pkt_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_INPUTS-1:0]                   axis_in_tvalid,
    output logic [NUM_INPUTS-1:0]                   axis_in_tready,
    input  logic [NUM_INPUTS-1:0]                   axis_in_tlast,
    input  logic [NUM_INPUTS-1:0][TDATA_WIDTH-1:0]  axis_in_tdata,
    input  logic [NUM_INPUTS-1:0][TDEST_WIDTH-1:0]  axis_in_tdest,
    input  logic [NUM_INPUTS-1:0][TID_WIDTH-1:0]    axis_in_tid,
    output logic                                    axis_out_tvalid,
    input  logic                                    axis_out_tready,
    output logic                                    axis_out_tlast,
    output logic [TDATA_WIDTH-1:0]                  axis_out_tdata,
    output logic [TDEST_WIDTH-1:0]                  axis_out_tdest,
    output logic [TID_WIDTH-1:0]                    axis_out_tid,
    output logic [idx_width(NUM_INPUTS)-1:0]        grant_id,
    output logic                                    locked
);

    localparam int GW = idx_width(NUM_INPUTS);

    arb_state_t            state;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         sel;
    logic                  sel_valid;
    logic [NUM_INPUTS-1:0] arb_gnt;
    logic                  arb_valid;
    logic                  out_reg_ready;
    logic                  fire;

    rr_arbiter #(
        .N(NUM_INPUTS)
    ) u_rr (
        .req  (axis_in_tvalid),
        .ptr  (rr_ptr),
        .gnt  (arb_gnt),
        .valid(arb_valid)
    );

    // Served input: fresh round-robin pick in IDLE, held grant in LOCKED
    always_comb begin
        sel       = grant_id;
        sel_valid = 1'b1;
        if (state == IDLE) begin
            sel       = '0;
            sel_valid = arb_valid;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (arb_gnt[i]) sel = GW'(i);
            end
        end
    end

    assign out_reg_ready = !axis_out_tvalid || axis_out_tready;
    assign fire = !rst && sel_valid && axis_in_tvalid[sel] && out_reg_ready;

    // Only the served input sees tready, and only when the output can load
    always_comb begin
        axis_in_tready = '0;
        if (!rst && sel_valid && out_reg_ready) axis_in_tready[sel] = 1'b1;
    end

    // Packet lock FSM, round-robin pointer and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            grant_id        <= '0;
            locked          <= 1'b0;
            axis_out_tvalid <= 1'b0;
            axis_out_tlast  <= 1'b0;
            axis_out_tdata  <= '0;
            axis_out_tdest  <= '0;
            axis_out_tid    <= '0;
        end else if (fire) begin
            axis_out_tvalid <= 1'b1;
            axis_out_tlast  <= axis_in_tlast[sel];
            axis_out_tdata  <= axis_in_tdata[sel];
            axis_out_tdest  <= axis_in_tdest[sel];
            axis_out_tid    <= axis_in_tid[sel];
            grant_id        <= sel;
            if (axis_in_tlast[sel]) begin
                state  <= IDLE;
                locked <= 1'b0;
                rr_ptr <= (sel == GW'(NUM_INPUTS - 1)) ? '0 : sel + GW'(1);
            end else begin
                state  <= LOCKED;
                locked <= 1'b1;
            end
        end else if (axis_out_tready) begin
            axis_out_tvalid <= 1'b0;
        end
    end

endmodule
